result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter ARRAY_SIZE, default 4, SHALL set the PE array edge N (N*N PEs, row-major index = row*N + col).
REQ-002 Parameter DATA_W, default 32, SHALL set the width of each PE accumulator result.
REQ-003 Ports SHALL be exactly, clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- finish  input  N*N  per-PE finish pulse from the finish-signal generator; bit k belongs to PE k.
- pe_result  input  N*N*DATA_W  flattened PE accumulators; slice k is bits [k*DATA_W +: DATA_W].
- flush  input  1  synchronous clear of all pending entries and the output register.
- out_data  output  DATA_W  result being offered.
- out_idx  output  clog2(N*N)  PE index of out_data.
- out_valid  output  1  out_data/out_idx valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- tile_done  output  1  one-cycle pulse when the N*N-th result of a tile is accepted.
- overflow  output  1  sticky error flag.

Function
REQ-004 On each rising edge where finish[k]=1, the block SHALL copy pe_result slice k into capture entry k and set pending[k]; multiple finish bits in one cycle SHALL all be captured.
REQ-005 When the output register is empty or is being handshaken (out_valid & out_ready), it SHALL load the lowest-indexed pending entry, clearing that pending bit in the same edge.
REQ-006 Latency: finish[k] high in cycle t with no other pending entries and an empty output register SHALL give out_valid=1, out_idx=k in cycle t+2.
REQ-007 out_data/out_idx SHALL stay stable while out_valid=1 and out_ready=0.
REQ-008 Sustained throughput SHALL be one result per cycle while out_ready=1 and entries are pending.
REQ-009 finish[k] while pending[k]=1 and entry k is not being loaded that edge SHALL discard the new value, keep the old one, and set overflow.
REQ-010 finish[k] in the same edge entry k is loaded into the output register SHALL capture the new value and leave pending[k]=1, with no overflow.
REQ-011 An accepted-result counter, width clog2(N*N)+1, SHALL increment per handshake; on reaching N*N it SHALL pulse tile_done for one cycle and wrap to 0 in the same edge.
REQ-012 flush SHALL clear pending, out_valid and the counter next edge, and SHALL take priority over finish and handshake that edge; overflow is unaffected.
REQ-013 overflow SHALL clear only on rst.

Reset
REQ-014 rst=1 SHALL asynchronously force out_valid=0, tile_done=0, overflow=0, out_data=0, out_idx=0, pending=0, counter=0.
REQ-015 Capture entry contents need not be reset; they are unobservable while pending=0.
REQ-016 Release of rst SHALL be glitch-free; the first capture is possible on the first edge after deassertion.

Structure
REQ-017 The index width function and the default ARRAY_SIZE/DATA_W SHALL live in the shared package used by the array wrapper and the finish-signal generator.
REQ-018 The lowest-index pending selector SHALL be one sub-module, priority_pick, parameterised by width, returning index and any-set flag.

Verification (N=4, DATA_W=16)
REQ-019 finish=16'h0001, pe_result slice0=16'h00AB, out_ready=1 -> cycle t+2: out_valid=1, out_idx=0, out_data=16'h00AB, then out_valid=0.
REQ-020 finish=16'h8421 in one cycle, out_ready=1 -> idx 0,5,10,15 on four consecutive cycles.
REQ-021 out_ready=0 for 5 cycles with idx 3 offered -> out_idx=3 and out_data held; after out_ready=1, next result follows one cycle later.
REQ-022 finish[2] twice, values 7 then 9, out_ready=0 -> overflow=1, out_data=7 offered; a later rst clears overflow.
REQ-023 Full diagonal finish wavefront over 4 cycles (all 16 PEs) -> 16 accepted results, tile_done pulses exactly once on the 16th handshake.
REQ-024 rst asserted mid-stream with 6 entries pending -> out_valid=0 immediately (before next edge); no stale results after release.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared defaults and index-width helper for the PE array, the finish-signal
// generator and the result collector.
package result_collector_pkg;

    localparam int unsigned DEFAULT_ARRAY_SIZE = 4;
    localparam int unsigned DEFAULT_DATA_W     = 32;

    // A single-entry array still needs a one-bit index port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/priority_pick.sv
// Lowest-index-first selector: reports the smallest set bit of req_i and
// whether any bit is set at all.
module priority_pick
    import result_collector_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0]        req_i,
    output logic [idx_w(Width)-1:0] idx_o,
    output logic                    any_o
);

    localparam int unsigned IdxW = idx_w(Width);

    // Scan downwards so the last hit, which wins, is the lowest index.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IdxW'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Captures per-PE accumulator results on their finish pulses and streams them
// out lowest-index-first over a valid/ready port, flagging tile completion.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [ARRAY_SIZE*ARRAY_SIZE-1:0]        finish,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] pe_result,
    input  logic                                    flush,
    output logic [DATA_W-1:0]                       out_data,
    output logic [idx_w(ARRAY_SIZE*ARRAY_SIZE)-1:0] out_idx,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    tile_done,
    output logic                                    overflow
);

    localparam int unsigned NumPe = ARRAY_SIZE * ARRAY_SIZE;
    localparam int unsigned IdxW  = idx_w(NumPe);
    localparam int unsigned CntW  = $clog2(NumPe) + 1;

    logic [DATA_W-1:0] entry_q [NumPe];
    logic [NumPe-1:0]  pending_q, pending_d;
    logic [NumPe-1:0]  capture;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IdxW-1:0]   out_idx_q, out_idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tile_done_q, tile_done_d;
    logic              overflow_q, overflow_d;

    logic [IdxW-1:0]   pick_idx;
    logic              pick_any;
    logic              advance;
    logic              handshake;
    logic              load;

    priority_pick #(
        .Width (NumPe)
    ) u_pick (
        .req_i (pending_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign handshake = out_valid_q & out_ready;
    assign advance   = ~out_valid_q | out_ready;
    assign load      = advance & pick_any;

    // A finish on an entry that is leaving this edge refills it; otherwise a
    // finish on a still-pending entry loses the new value.
    always_comb begin
        pending_d  = pending_q;
        capture    = '0;
        overflow_d = overflow_q;
        if (load) begin
            pending_d[pick_idx] = 1'b0;
        end
        for (int k = 0; k < int'(NumPe); k++) begin
            if (finish[k]) begin
                if (pending_q[k] && !(load && pick_idx == IdxW'(k))) begin
                    overflow_d = 1'b1;
                end else begin
                    capture[k]   = 1'b1;
                    pending_d[k] = 1'b1;
                end
            end
        end
        if (flush) begin
            pending_d  = '0;
            capture    = '0;
            overflow_d = overflow_q;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        if (advance) begin
            out_valid_d = pick_any;
            if (pick_any) begin
                out_data_d = entry_q[pick_idx];
                out_idx_d  = pick_idx;
            end
        end
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        tile_done_d = 1'b0;
        if (handshake) begin
            if (cnt_q == CntW'(NumPe - 1)) begin
                cnt_d       = '0;
                tile_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        if (flush) begin
            cnt_d       = '0;
            tile_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage is only observable through pending, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NumPe); k++) begin
            if (capture[k]) begin
                entry_q[k] <= pe_result[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign tile_done = tile_done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector (N=4, DATA_W=16): directed scenarios
// plus randomized traffic checked against a transaction-level reference model.
module tb_result_collector;

    localparam int N  = 4;
    localparam int NP = N * N;
    localparam int DW = 16;

    logic               clk;
    logic               rst;
    logic [NP-1:0]      finish;
    logic [NP*DW-1:0]   pe_result;
    logic               flush;
    logic [DW-1:0]      out_data;
    logic [3:0]         out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               tile_done;
    logic               overflow;

    int checks;
    int errors;

    // Reference model state
    bit          m_pend [NP];
    logic [15:0] m_ent  [NP];
    bit          m_valid;
    logic [15:0] m_data;
    logic [3:0]  m_idx;
    int          m_cnt;
    bit          m_tile;
    bit          m_ovf;

    result_collector #(
        .ARRAY_SIZE (N),
        .DATA_W     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .finish    (finish),
        .pe_result (pe_result),
        .flush     (flush),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tile_done (tile_done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic m_reset();
        for (int k = 0; k < NP; k++) m_pend[k] = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_idx   = '0;
        m_cnt   = 0;
        m_tile  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the reference: results queue per PE, oldest output
    // leaves on acceptance, the smallest waiting PE index goes next.
    task automatic m_step();
        bit old_pend [NP];
        int sel;
        bit adv;
        if (flush) begin
            for (int k = 0; k < NP; k++) m_pend[k] = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_idx   = '0;
            m_cnt   = 0;
            m_tile  = 1'b0;
            return;
        end
        adv    = !m_valid || out_ready;
        m_tile = 1'b0;
        if (m_valid && out_ready) begin
            m_cnt++;
            if (m_cnt == NP) begin
                m_cnt  = 0;
                m_tile = 1'b1;
            end
        end
        sel = -1;
        for (int k = NP - 1; k >= 0; k--) if (m_pend[k]) sel = k;
        for (int k = 0; k < NP; k++) old_pend[k] = m_pend[k];
        if (adv) begin
            if (sel >= 0) begin
                m_valid      = 1'b1;
                m_data       = m_ent[sel];
                m_idx        = 4'(sel);
                m_pend[sel]  = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int k = 0; k < NP; k++) begin
            if (finish[k]) begin
                if (old_pend[k] && !(adv && sel == k)) begin
                    m_ovf = 1'b1;
                end else begin
                    m_ent[k]  = pe_result[k*DW +: DW];
                    m_pend[k] = 1'b1;
                end
            end
        end
    endtask

    // Advance one edge; outputs are then observed at the following negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, tile_done, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {out_valid, tile_done, overflow});
        end
        checks++;
        if (out_data !== 16'h0 || out_idx !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: got data=%h idx=%0d expected 0/0", out_data, out_idx);
        end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_single();
        finish              = 16'h0001;
        pe_result[15:0]     = 16'h00AB;
        out_ready           = 1'b1;
        cycle();
        finish = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: got valid=%b expected 0", out_valid);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== 16'h00AB) begin
            errors++;
            $display("FAIL single_t2: got v=%b idx=%0d data=%h expected 1/0/00ab",
                     out_valid, out_idx, out_data);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_diag();
        logic [15:0] vals [NP];
        int          exp_idx [4];
        exp_idx = '{0, 5, 10, 15};
        for (int k = 0; k < NP; k++) begin
            vals[k] = 16'($urandom);
            pe_result[k*DW +: DW] = vals[k];
        end
        finish    = 16'h8421;
        out_ready = 1'b1;
        cycle();
        finish = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'(exp_idx[i]) ||
                out_data !== vals[exp_idx[i]]) begin
                errors++;
                $display("FAIL diag_%0d: got v=%b idx=%0d data=%h expected 1/%0d/%h",
                         i, out_valid, out_idx, out_data, exp_idx[i], vals[exp_idx[i]]);
            end
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL diag_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [15:0] d3, d6;
        d3 = 16'($urandom);
        d6 = 16'($urandom);
        pe_result[3*DW +: DW] = d3;
        pe_result[6*DW +: DW] = d6;
        finish    = 16'h0048;
        out_ready = 1'b0;
        cycle();
        finish = '0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            pe_result = {8{32'($urandom)}};
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'd3 || out_data !== d3) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b idx=%0d data=%h expected 1/3/%h",
                         i, out_valid, out_idx, out_data, d3);
            end
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd6 || out_data !== d6) begin
            errors++;
            $display("FAIL stall_next: got v=%b idx=%0d data=%h expected 1/6/%h",
                     out_valid, out_idx, out_data, d6);
        end
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        finish    = 16'h00F0;
        cycle();
        finish = '0;
        cycle();
        flush  = 1'b1;
        finish = 16'h0100;
        cycle();
        flush  = 1'b0;
        finish = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b expected 0", out_valid);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_cleared: got v=%b ovf=%b expected 0/0", out_valid, overflow);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        finish    = 16'h0001;
        pe_result[15:0] = 16'h0055;
        cycle();
        finish = 16'h0004;
        pe_result[2*DW +: DW] = 16'd7;
        cycle();
        pe_result[2*DW +: DW] = 16'd9;
        cycle();
        finish = '0;
        checks++;
        if (overflow !== 1'b1 || out_idx !== 4'd0) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b idx=%0d expected 1/0", overflow, out_idx);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd2 || out_data !== 16'd7) begin
            errors++;
            $display("FAIL ovf_keep_old: got v=%b idx=%0d data=%0d expected 1/2/7",
                     out_valid, out_idx, out_data);
        end
        cycle();
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b v=%b expected 1/0", overflow, out_valid);
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_rst: got %b expected 0", overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_tile();
        int  acc;
        int  pulses;
        bit  hs;
        acc    = 0;
        pulses = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 44; c++) begin
            finish = '0;
            if (c < 4) begin
                for (int r = 0; r < N; r++)
                    for (int col = 0; col < N; col++)
                        if ((r + col) % N == c) begin
                            finish[r*N + col] = 1'b1;
                            pe_result[(r*N + col)*DW +: DW] = 16'($urandom);
                        end
            end
            hs = out_valid && out_ready;
            cycle();
            if (hs) acc++;
            if (tile_done === 1'b1) begin
                pulses++;
                checks++;
                if (acc != NP) begin
                    errors++;
                    $display("FAIL tile_pulse_pos: got pulse after %0d accepts expected %0d",
                             acc, NP);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== m_data || out_idx !== m_idx) begin
                    errors++;
                    $display("FAIL tile_data: got idx=%0d data=%h expected %0d/%h",
                             out_idx, out_data, m_idx, m_data);
                end
            end
        end
        finish = '0;
        checks++;
        if (acc != NP || pulses != 1) begin
            errors++;
            $display("FAIL tile_count: got accepts=%0d pulses=%0d expected %0d/1",
                     acc, pulses, NP);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        finish    = 16'h0F03;
        cycle();
        finish = '0;
        cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: got v=%b idx=%0d data=%h expected 0/0/0",
                     out_valid, out_idx, out_data);
        end
        m_reset();
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale_%0d: got valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            finish    = 16'($urandom) & 16'($urandom);
            pe_result = {8{32'($urandom)}};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            cycle();
            checks++;
            if (out_valid !== m_valid || tile_done !== m_tile || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_flags c=%0d: got v=%b td=%b ovf=%b expected %b/%b/%b",
                         c, out_valid, tile_done, overflow, m_valid, m_tile, m_ovf);
            end
            checks++;
            if (out_data !== m_data || out_idx !== m_idx) begin
                errors++;
                $display("FAIL rand_data c=%0d: got idx=%0d data=%h expected %0d/%h",
                         c, out_idx, out_data, m_idx, m_data);
            end
        end
        finish = '0;
        flush  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        finish    = '0;
        pe_result = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_reset();
        test_reset();
        test_single();
        test_diag();
        test_stall();
        test_flush();
        test_overflow();
        test_tile();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
